// File: rtl/qpu_exu_timeq_pkg.sv
// rtl/qpu_exu_timeq_pkg.sv - shared widths and FSM encodings for the timing queue
package qpu_exu_timeq_pkg;

    localparam int QPU_TIME_WIDTH       = 32;
    localparam int QPU_EVENT_WIRE_WIDTH = 32;
    localparam int QPU_EVENT_NUM        = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/qpu_timeq_fifo.sv
// rtl/qpu_timeq_fifo.sv - synchronous FIFO with wrap-bit pointers and flush
module qpu_timeq_fifo #(
    parameter int W     = 72,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Pointers differ only in the wrap bit when every slot is occupied.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush returns the queue to its empty state.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/qpu_exu_timeq.sv
// rtl/qpu_exu_timeq.sv - timed event queue issuing event words when their time point is reached
module qpu_exu_timeq
    import qpu_exu_timeq_pkg::*;
#(
    parameter int TIME_W = QPU_TIME_WIDTH,
    parameter int EVW_W  = QPU_EVENT_WIRE_WIDTH,
    parameter int EVN    = QPU_EVENT_NUM,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tiq_wbck_i_ena,
    input  logic [TIME_W-1:0] tiq_wbck_i_data,
    output logic              tiq_wbck_i_ready,
    input  logic              evq_wbck_i_ena,
    input  logic [EVW_W-1:0]  evq_wbck_i_data,
    input  logic [EVN-1:0]    evq_wbck_i_oprand,
    output logic              evq_wbck_i_ready,
    input  logic              timer_start_i,
    input  logic              timer_stop_i,
    input  logic              flush_i,
    output logic              evt_o_valid,
    output logic [EVW_W-1:0]  evt_o_data,
    output logic [EVN-1:0]    evt_o_oprand,
    output logic              evt_o_late,
    output logic [TIME_W-1:0] timer_o,
    output logic              q_empty_o,
    output logic              proto_err_o
);

    localparam int FW = TIME_W + EVW_W + EVN;
    localparam logic [TIME_W-1:0] TIME_ONE = {{(TIME_W-1){1'b0}}, 1'b1};
    localparam logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}};

    logic [0:0]        state;
    logic [TIME_W-1:0] timer;
    logic              full;
    logic              empty;
    logic [FW-1:0]     head;
    logic [TIME_W-1:0] head_time;
    logic [EVW_W-1:0]  head_data;
    logic [EVN-1:0]    head_oprand;
    logic              push;
    logic              pop;

    assign {head_time, head_data, head_oprand} = head;

    // A write needs both halves of the entry; flush discards a same-cycle write.
    assign push = tiq_wbck_i_ena && evq_wbck_i_ena && !full && !flush_i;
    assign pop  = (state == ST_RUN) && !empty && (timer >= head_time) && !flush_i;

    assign tiq_wbck_i_ready = !full;
    assign evq_wbck_i_ready = !full;
    assign q_empty_o        = empty;
    assign timer_o          = timer;

    qpu_timeq_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush_i),
        .wdata ({tiq_wbck_i_data, evq_wbck_i_data, evq_wbck_i_oprand}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Run/idle control and saturating experiment timer; start beats stop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            timer <= '0;
        end else if (timer_start_i) begin
            state <= ST_RUN;
            timer <= '0;
        end else if (timer_stop_i) begin
            state <= ST_IDLE;
        end else if (state == ST_RUN && timer != TIME_MAX) begin
            timer <= timer + TIME_ONE;
        end
    end

    // Registered issue pulse; payload holds its last value between pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_o_valid  <= 1'b0;
            evt_o_data   <= '0;
            evt_o_oprand <= '0;
            evt_o_late   <= 1'b0;
        end else begin
            evt_o_valid <= pop;
            if (pop) begin
                evt_o_data   <= head_data;
                evt_o_oprand <= head_oprand;
                evt_o_late   <= (timer > head_time);
            end
        end
    end

    // Sticky protocol error when only one of the two write enables is raised.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            proto_err_o <= 1'b0;
        end else if (tiq_wbck_i_ena ^ evq_wbck_i_ena) begin
            proto_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_qpu_exu_timeq.sv
// tb/tb_qpu_exu_timeq.sv - scoreboard bench for qpu_exu_timeq
module tb_qpu_exu_timeq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tiq_wbck_i_ena;
    logic [31:0] tiq_wbck_i_data;
    logic        tiq_wbck_i_ready;
    logic        evq_wbck_i_ena;
    logic [31:0] evq_wbck_i_data;
    logic [7:0]  evq_wbck_i_oprand;
    logic        evq_wbck_i_ready;
    logic        timer_start_i;
    logic        timer_stop_i;
    logic        flush_i;
    logic        evt_o_valid;
    logic [31:0] evt_o_data;
    logic [7:0]  evt_o_oprand;
    logic        evt_o_late;
    logic [31:0] timer_o;
    logic        q_empty_o;
    logic        proto_err_o;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  op;
        logic        late;
        logic [31:0] at_timer;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qpu_exu_timeq dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .tiq_wbck_i_ena    (tiq_wbck_i_ena),
        .tiq_wbck_i_data   (tiq_wbck_i_data),
        .tiq_wbck_i_ready  (tiq_wbck_i_ready),
        .evq_wbck_i_ena    (evq_wbck_i_ena),
        .evq_wbck_i_data   (evq_wbck_i_data),
        .evq_wbck_i_oprand (evq_wbck_i_oprand),
        .evq_wbck_i_ready  (evq_wbck_i_ready),
        .timer_start_i     (timer_start_i),
        .timer_stop_i      (timer_stop_i),
        .flush_i           (flush_i),
        .evt_o_valid       (evt_o_valid),
        .evt_o_data        (evt_o_data),
        .evt_o_oprand      (evt_o_oprand),
        .evt_o_late        (evt_o_late),
        .timer_o           (timer_o),
        .q_empty_o         (q_empty_o),
        .proto_err_o       (proto_err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] t, input logic [31:0] d, input logic [7:0] op);
        tiq_wbck_i_ena    = 1'b1;
        evq_wbck_i_ena    = 1'b1;
        tiq_wbck_i_data   = t;
        evq_wbck_i_data   = d;
        evq_wbck_i_oprand = op;
        step();
        tiq_wbck_i_ena = 1'b0;
        evq_wbck_i_ena = 1'b0;
    endtask

    task automatic expect_evt(input logic [31:0] d, input logic [7:0] op,
                              input logic late, input logic [31:0] at);
        exp_t e;
        e.data = d; e.op = op; e.late = late; e.at_timer = at;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        timer_start_i = 1'b1; step(); timer_start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        timer_stop_i = 1'b1; step(); timer_stop_i = 1'b0;
    endtask

    task automatic drain(input string tag, input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) step();
        step();
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_timer(input string tag, input logic [31:0] t, input int bound);
        for (int i = 0; i < bound && timer_o != t; i++) step();
        check(tag, 64'(timer_o), 64'(t));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tiq_ready"}, 64'(tiq_wbck_i_ready), 64'd1);
        check({tag, "_evq_ready"}, 64'(evq_wbck_i_ready), 64'd1);
        check({tag, "_empty"},     64'(q_empty_o),        64'd1);
        check({tag, "_valid"},     64'(evt_o_valid),      64'd0);
        check({tag, "_data"},      64'(evt_o_data),       64'd0);
        check({tag, "_oprand"},    64'(evt_o_oprand),     64'd0);
        check({tag, "_late"},      64'(evt_o_late),       64'd0);
        check({tag, "_timer"},     64'(timer_o),          64'd0);
        check({tag, "_proto"},     64'(proto_err_o),      64'd0);
    endtask

    // Scoreboard: every issue pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && evt_o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_evt", 64'(evt_o_data), 64'hDEAD_0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("evt_data",  64'(evt_o_data),   64'(e.data));
                check("evt_op",    64'(evt_o_oprand), 64'(e.op));
                check("evt_late",  64'(evt_o_late),   64'(e.late));
                check("evt_timer", 64'(timer_o),      64'(e.at_timer));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        tiq_wbck_i_ena = 1'b0; evq_wbck_i_ena = 1'b0;
        tiq_wbck_i_data = '0; evq_wbck_i_data = '0; evq_wbck_i_oprand = '0;
        timer_start_i = 1'b0; timer_stop_i = 1'b0; flush_i = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_reset_outputs("reset");

        // 1: single event at t=5, pushed at timer=1
        pulse_start();
        step();
        check("t1_timer_at_push", 64'(timer_o), 64'd1);
        expect_evt(32'hA5, 8'h01, 1'b0, 32'd6);
        push(32'd5, 32'hA5, 8'h01);
        drain("t1_drain", 30);
        check("t1_empty_after", 64'(q_empty_o), 64'd1);

        // 2: three equal time points pushed while idle
        pulse_stop();
        expect_evt(32'h11, 8'h01, 1'b0, 32'd4);
        expect_evt(32'h22, 8'h02, 1'b1, 32'd5);
        expect_evt(32'h33, 8'h03, 1'b1, 32'd6);
        push(32'd3, 32'h11, 8'h01);
        push(32'd3, 32'h22, 8'h02);
        push(32'd3, 32'h33, 8'h03);
        pulse_start();
        drain("t2_drain", 30);

        // 3: fill to full, ninth push dropped, ready returns after one pop
        pulse_stop();
        for (int i = 0; i < 8; i++) begin
            expect_evt(32'h100 + 32'(i), 8'(i), (i != 0), 32'd101 + 32'(i));
            push(32'd100, 32'h100 + 32'(i), 8'(i));
        end
        check("t3_ready_full", 64'(tiq_wbck_i_ready), 64'd0);
        check("t3_evq_ready_full", 64'(evq_wbck_i_ready), 64'd0);
        push(32'd100, 32'hBAD, 8'hFF);
        check("t3_still_full", 64'(tiq_wbck_i_ready), 64'd0);
        pulse_start();
        wait_timer("t3_reach_101", 32'd101, 200);
        check("t3_ready_after_pop", 64'(tiq_wbck_i_ready), 64'd1);
        drain("t3_drain", 30);

        // 4: enable mismatch
        pulse_stop();
        tiq_wbck_i_ena = 1'b1; tiq_wbck_i_data = 32'd7;
        step();
        tiq_wbck_i_ena = 1'b0;
        check("t4_empty", 64'(q_empty_o), 64'd1);
        check("t4_proto", 64'(proto_err_o), 64'd1);
        repeat (5) step();
        check("t4_proto_sticky", 64'(proto_err_o), 64'd1);
        rst_n = 1'b0; step(); rst_n = 1'b1; step();
        check("t4_proto_cleared", 64'(proto_err_o), 64'd0);

        // 5: stop mid-run, restart, issue relative to the new timer origin
        pulse_start();
        expect_evt(32'h55, 8'h05, 1'b0, 32'd21);
        push(32'd20, 32'h55, 8'h05);
        wait_timer("t5_reach_10", 32'd10, 50);
        pulse_stop();
        check("t5_stop_hold", 64'(timer_o), 64'd10);
        repeat (30) step();
        check("t5_idle_hold", 64'(timer_o), 64'd10);
        check("t5_still_queued", 64'(q_empty_o), 64'd0);
        pulse_start();
        check("t5_restart", 64'(timer_o), 64'd0);
        drain("t5_drain", 40);

        // 6: flush with concurrent push, then reset during run
        pulse_stop();
        for (int i = 0; i < 4; i++) push(32'd2, 32'h600 + 32'(i), 8'h06);
        check("t6_not_empty", 64'(q_empty_o), 64'd0);
        flush_i = 1'b1;
        tiq_wbck_i_ena = 1'b1; evq_wbck_i_ena = 1'b1;
        tiq_wbck_i_data = 32'd1; evq_wbck_i_data = 32'h6FF;
        step();
        flush_i = 1'b0; tiq_wbck_i_ena = 1'b0; evq_wbck_i_ena = 1'b0;
        check("t6_flushed", 64'(q_empty_o), 64'd1);
        pulse_start();
        repeat (20) step();
        check("t6_no_issue", 64'(q_empty_o), 64'd1);
        push(32'd1000, 32'h777, 8'h07);
        repeat (3) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check_reset_outputs("t6_reset");

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
